// File: rtl/noc_pkg.sv
// Shared definitions for the mesh NoC router input port: direction codes,
// routing FSM encoding, coordinate extraction and the XY routing rule.
package noc_pkg;

    localparam logic [4:0] DIR_L  = 5'b10000;
    localparam logic [4:0] DIR_R  = 5'b01000;
    localparam logic [4:0] DIR_U  = 5'b00100;
    localparam logic [4:0] DIR_D  = 5'b00010;
    localparam logic [4:0] DIR_PE = 5'b00001;

    localparam int MAX_COORD_W = 16;

    typedef logic [MAX_COORD_W-1:0]   coord_t;
    typedef logic [2*MAX_COORD_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_REQ   = 2'd2,
        ST_DROP  = 2'd3
    } state_e;

    // addr holds {x,y} right-aligned, each field coord_w bits wide.
    function automatic coord_t coord_field(input addr_t addr, input int unsigned coord_w,
                                           input logic sel_x);
        addr_t shifted;
        addr_t mask;
        shifted = sel_x ? (addr >> coord_w) : addr;
        mask    = {(2*MAX_COORD_W){1'b1}} >> (2*MAX_COORD_W - coord_w);
        return coord_t'(shifted & mask);
    endfunction

    function automatic logic [4:0] xy_route(input coord_t dx, input coord_t dy,
                                            input coord_t cx, input coord_t cy);
        if (dx > cx)      return DIR_R;
        else if (dx < cx) return DIR_L;
        else if (dy > cy) return DIR_U;
        else if (dy < cy) return DIR_D;
        else              return DIR_PE;
    endfunction

endpackage

// File: rtl/noc_input_port_if.sv
// Upstream flit handshake plus crossbar request/grant bundle of one router input.
interface noc_input_port_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  si;
    logic                  ri;
    logic [DATA_WIDTH-1:0] datai;
    logic [4:0]            req;
    logic [4:0]            gnt;
    logic [DATA_WIDTH-1:0] datao;

    modport master (output si, datai, gnt, input ri, req, datao);
    modport slave  (input si, datai, gnt, output ri, req, datao);
endinterface

// File: rtl/noc_sync_fifo.sv
// Power-of-two circular flit buffer with synchronous clear that overrides push/pop.
module noc_sync_fifo #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic                            clear,
    input  logic [DATA_WIDTH-1:0]           din,
    output logic [DATA_WIDTH-1:0]           head,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(BUFFER_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap for free because the depth is a power of two.
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(BUFFER_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers flits, XY-routes the head flit, requests the crossbar
// and drops U-turn flits with a saturating drop counter.
//   state    | meaning
//   ST_IDLE  | buffer empty, nothing requested
//   ST_ROUTE | route of head flit being registered
//   ST_REQ   | req/datao held until a matching grant pops the head
//   ST_DROP  | head is a U-turn flit; pop it and count it
module noc_input_port
    import noc_pkg::*;
#(
    parameter int                 DATA_WIDTH      = 64,
    parameter int                 COORD_W         = 8,
    parameter logic [2*COORD_W-1:0] CURRENT_ADDRESS = 16'h0000,
    parameter logic [4:0]         DIRECTION       = 5'b00001,
    parameter int                 BUFFER_DEPTH    = 4,
    parameter int                 ERR_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_buffer_clear,
    noc_input_port_if.slave      port,
    output logic [ERR_W-1:0]     err_cnt
);
    localparam int    CNT_W   = $clog2(BUFFER_DEPTH) + 1;
    localparam addr_t CUR_EXT = addr_t'(CURRENT_ADDRESS);

    state_e                state_q, state_d;
    logic [4:0]            req_q, req_d;
    logic [DATA_WIDTH-1:0] datao_q, datao_d;
    logic [ERR_W-1:0]      err_q, err_d;

    logic                  push, pop, full, empty, remaining;
    logic [DATA_WIDTH-1:0] head;
    logic [CNT_W-1:0]      count;
    addr_t                 head_addr;
    logic [4:0]            route;

    noc_sync_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .clear(sig_buffer_clear),
        .din  (port.datai),
        .head (head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    assign port.ri = !full;
    assign push    = port.si && !full;

    always_comb begin
        head_addr                = '0;
        head_addr[2*COORD_W-1:0] = head[2*COORD_W-1:0];
    end

    assign route = xy_route(coord_field(head_addr, COORD_W, 1'b1),
                            coord_field(head_addr, COORD_W, 1'b0),
                            coord_field(CUR_EXT, COORD_W, 1'b1),
                            coord_field(CUR_EXT, COORD_W, 1'b0));

    // After popping, another flit is waiting if one was left behind or arrives now.
    assign remaining = (count > CNT_W'(1)) || push;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        datao_d = datao_q;
        err_d   = err_q;
        pop     = 1'b0;
        if (sig_buffer_clear) begin
            state_d = ST_IDLE;
            req_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) state_d = ST_ROUTE;
                end
                ST_ROUTE: begin
                    if (route == DIRECTION && DIRECTION != DIR_PE) begin
                        state_d = ST_DROP;
                    end else begin
                        req_d   = route;
                        datao_d = head;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if ((port.gnt & req_q) != 5'b0) begin
                        pop     = 1'b1;
                        req_d   = '0;
                        state_d = remaining ? ST_ROUTE : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    pop     = 1'b1;
                    if (err_q != '1) err_d = err_q + 1'b1;
                    state_d = remaining ? ST_ROUTE : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            datao_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            datao_q <= datao_d;
            err_q   <= err_d;
        end
    end

    assign port.req   = req_q;
    assign port.datao = datao_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port: a PE-side and an L-side instance at router 0x0303,
// checked against a flit-queue reference model and XY routing arithmetic.
module tb_noc_input_port;
    import noc_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int EW    = 8;
    localparam int CX    = 3;
    localparam int CY    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_pe, clr_l;
    logic [EW-1:0] err_pe, err_l;

    always #5 clk = ~clk;

    noc_input_port_if #(.DATA_WIDTH(DW)) pe_if ();
    noc_input_port_if #(.DATA_WIDTH(DW)) l_if ();

    noc_input_port #(
        .DATA_WIDTH(DW), .COORD_W(8), .CURRENT_ADDRESS(16'h0303),
        .DIRECTION(DIR_PE), .BUFFER_DEPTH(DEPTH), .ERR_W(EW)
    ) dut_pe (
        .clk(clk), .rst(rst), .sig_buffer_clear(clr_pe), .port(pe_if.slave), .err_cnt(err_pe)
    );

    noc_input_port #(
        .DATA_WIDTH(DW), .COORD_W(8), .CURRENT_ADDRESS(16'h0303),
        .DIRECTION(DIR_L), .BUFFER_DEPTH(DEPTH), .ERR_W(EW)
    ) dut_l (
        .clk(clk), .rst(rst), .sig_buffer_clear(clr_l), .port(l_if.slave), .err_cnt(err_l)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q_pe[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ref_route(input logic [DW-1:0] f);
        int dx, dy;
        dx = int'(f[15:8]);
        dy = int'(f[7:0]);
        if (dx > CX) return DIR_R;
        if (dx < CX) return DIR_L;
        if (dy > CY) return DIR_U;
        if (dy < CY) return DIR_D;
        return DIR_PE;
    endfunction

    function automatic logic [DW-1:0] rand_flit(input int max_coord);
        logic [DW-1:0] f;
        f        = {$urandom, $urandom};
        f[15:8]  = 8'($urandom_range(0, max_coord));
        f[7:0]   = 8'($urandom_range(0, max_coord));
        return f;
    endfunction

    function automatic logic [DW-1:0] uturn_flit();
        logic [DW-1:0] f;
        f       = {$urandom, $urandom};
        f[15:8] = 8'($urandom_range(0, CX - 1));
        return f;
    endfunction

    // One clock: update the model from the pre-edge handshake, then check outputs.
    task automatic tick();
        bit            acc, popped, cleared, in_rst;
        logic [DW-1:0] d;
        in_rst  = rst;
        cleared = clr_pe;
        acc     = pe_if.si && (q_pe.size() < DEPTH);
        popped  = (pe_if.req != 5'b0) && ((pe_if.gnt & pe_if.req) != 5'b0);
        d       = pe_if.datai;
        @(posedge clk);
        #1;
        if (in_rst || cleared) begin
            q_pe.delete();
        end else begin
            if (popped) void'(q_pe.pop_front());
            if (acc) q_pe.push_back(d);
        end
        if (!in_rst) begin
            check("pe_ri", 64'(pe_if.ri), 64'(q_pe.size() < DEPTH));
            if (q_pe.size() == 0 || popped || cleared) begin
                check("pe_req_idle", 64'(pe_if.req), 64'd0);
            end else if (pe_if.req != 5'b0) begin
                check("pe_datao", pe_if.datao, q_pe[0]);
                check("pe_req_route", 64'(pe_if.req), 64'(ref_route(q_pe[0])));
            end
            check("l_no_uturn_req", 64'(l_if.req == DIR_L), 64'd0);
        end
    endtask

    task automatic wait_req_pe(input int budget);
        int n = 0;
        while (pe_if.req == 5'b0 && n < budget) begin
            tick();
            n++;
        end
        check("pe_req_timeout", 64'(pe_if.req != 5'b0), 64'd1);
    endtask

    task automatic grant_pe();
        if (q_pe.size() != 0) pe_if.gnt = ref_route(q_pe[0]);
        tick();
        pe_if.gnt = 5'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] f;
        logic [DW-1:0] sent[6];
        logic [15:0]   dests[5];
        logic [4:0]    exp_r[5];
        int            acc, n, nsent;

        dests = '{16'h0503, 16'h0103, 16'h0305, 16'h0301, 16'h0303};
        exp_r = '{DIR_R, DIR_L, DIR_U, DIR_D, DIR_PE};

        rst = 1'b1; clr_pe = 1'b0; clr_l = 1'b0;
        pe_if.si = 1'b0; pe_if.datai = '0; pe_if.gnt = '0;
        l_if.si  = 1'b0; l_if.datai  = '0; l_if.gnt  = '0;

        // Reset and idle
        tick();
        tick();
        check("rst_req_pe", 64'(pe_if.req), 64'd0);
        check("rst_err_pe", 64'(err_pe), 64'd0);
        check("rst_ri_pe", 64'(pe_if.ri), 64'd1);
        check("rst_datao_pe", pe_if.datao, 64'd0);
        check("rst_req_l", 64'(l_if.req), 64'd0);
        check("rst_err_l", 64'(err_l), 64'd0);
        check("rst_ri_l", 64'(l_if.ri), 64'd1);
        rst = 1'b0;
        repeat (20) tick();

        // Basic XY routing and two-edge latency
        for (int i = 0; i < 5; i++) begin
            f = {$urandom, $urandom};
            f[15:0] = dests[i];
            pe_if.datai = f;
            pe_if.si = 1'b1;
            tick();
            pe_if.si = 1'b0;
            tick();
            check($sformatf("lat_early%0d", i), 64'(pe_if.req), 64'd0);
            tick();
            check($sformatf("route%0d", i), 64'(pe_if.req), 64'(exp_r[i]));
            check($sformatf("route_data%0d", i), pe_if.datao, f);
            pe_if.gnt = exp_r[i];
            tick();
            pe_if.gnt = 5'b0;
            check($sformatf("req_clear%0d", i), 64'(pe_if.req), 64'd0);
        end

        // Backpressure with no grants
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            sent[i] = rand_flit(6);
            pe_if.datai = sent[i];
            pe_if.si = 1'b1;
            if (pe_if.ri) acc++;
            tick();
        end
        pe_if.si = 1'b0;
        check("bp_accepted", 64'(acc), 64'd4);
        check("bp_ri_full", 64'(pe_if.ri), 64'd0);
        for (int i = 0; i < 4; i++) begin
            wait_req_pe(10);
            check($sformatf("bp_order%0d", i), pe_if.datao, sent[i]);
            pe_if.gnt = ref_route(sent[i]);
            tick();
            pe_if.gnt = 5'b0;
            if (i == 0) check("bp_ri_reassert", 64'(pe_if.ri), 64'd1);
        end
        tick();

        // Mismatched grant holds the request
        f = {$urandom, $urandom};
        f[15:0] = 16'h0103;
        pe_if.datai = f;
        pe_if.si = 1'b1;
        tick();
        pe_if.si = 1'b0;
        wait_req_pe(10);
        check("mm_req", 64'(pe_if.req), 64'(DIR_L));
        pe_if.gnt = DIR_U;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("mm_hold_req%0d", i), 64'(pe_if.req), 64'(DIR_L));
            check($sformatf("mm_hold_data%0d", i), pe_if.datao, f);
        end
        pe_if.gnt = DIR_L;
        tick();
        pe_if.gnt = 5'b0;
        check("mm_pop_req", 64'(pe_if.req), 64'd0);
        tick();

        // Flush with coincident push and grant
        for (int i = 0; i < 3; i++) begin
            pe_if.datai = rand_flit(6);
            pe_if.si = 1'b1;
            tick();
        end
        pe_if.si = 1'b0;
        wait_req_pe(10);
        pe_if.datai = rand_flit(6);
        pe_if.si = 1'b1;
        pe_if.gnt = ref_route(q_pe[0]);
        clr_pe = 1'b1;
        tick();
        clr_pe = 1'b0;
        pe_if.si = 1'b0;
        pe_if.gnt = 5'b0;
        check("flush_req", 64'(pe_if.req), 64'd0);
        check("flush_ri", 64'(pe_if.ri), 64'd1);
        repeat (8) tick();
        f = rand_flit(6);
        pe_if.datai = f;
        pe_if.si = 1'b1;
        tick();
        pe_if.si = 1'b0;
        wait_req_pe(10);
        check("flush_after_data", pe_if.datao, f);
        grant_pe();

        // Randomized traffic with occasional flush
        for (int c = 0; c < 400; c++) begin
            int r;
            pe_if.si = 1'($urandom_range(0, 1));
            pe_if.datai = rand_flit(6);
            r = int'($urandom_range(0, 3));
            if (r < 2 && q_pe.size() != 0) pe_if.gnt = ref_route(q_pe[0]);
            else if (r == 2) pe_if.gnt = 5'b00001 << $urandom_range(0, 4);
            else pe_if.gnt = 5'b0;
            clr_pe = ($urandom_range(0, 39) == 0);
            tick();
        end
        pe_if.si = 1'b0;
        clr_pe = 1'b0;
        pe_if.gnt = 5'b0;
        n = 0;
        while (q_pe.size() != 0 && n < 100) begin
            if (pe_if.req != 5'b0) pe_if.gnt = ref_route(q_pe[0]);
            else pe_if.gnt = 5'b0;
            tick();
            n++;
        end
        pe_if.gnt = 5'b0;
        check("drain_empty", 64'(q_pe.size()), 64'd0);
        check("pe_err_unchanged", 64'(err_pe), 64'd0);

        // U-turn drop on the L-side port
        l_if.datai = uturn_flit();
        l_if.datai[15:0] = 16'h0103;
        l_if.si = 1'b1;
        tick();
        l_if.si = 1'b0;
        repeat (6) tick();
        check("drop_one", 64'(err_l), 64'd1);
        check("drop_no_req", 64'(l_if.req), 64'd0);

        // Non-U-turn flit still routes on the L-side port
        f = {$urandom, $urandom};
        f[15:0] = 16'h0503;
        l_if.datai = f;
        l_if.si = 1'b1;
        tick();
        l_if.si = 1'b0;
        n = 0;
        while (l_if.req == 5'b0 && n < 10) begin
            tick();
            n++;
        end
        check("l_route_r", 64'(l_if.req), 64'(DIR_R));
        check("l_route_data", l_if.datao, f);
        l_if.gnt = DIR_R;
        tick();
        l_if.gnt = 5'b0;
        check("l_req_clear", 64'(l_if.req), 64'd0);
        check("l_err_kept", 64'(err_l), 64'd1);

        // Drop counter up to 200, then saturation after 256 drops
        nsent = 1;
        n = 0;
        while (nsent < 200 && n < 2000) begin
            l_if.si = 1'b1;
            l_if.datai = uturn_flit();
            if (l_if.ri) nsent++;
            tick();
            n++;
        end
        l_if.si = 1'b0;
        check("drop_feed_200", 64'(nsent), 64'd200);
        repeat (16) tick();
        check("err_200", 64'(err_l), 64'd200);
        n = 0;
        while (nsent < 256 && n < 2000) begin
            l_if.si = 1'b1;
            l_if.datai = uturn_flit();
            if (l_if.ri) nsent++;
            tick();
            n++;
        end
        l_if.si = 1'b0;
        check("drop_feed_256", 64'(nsent), 64'd256);
        repeat (16) tick();
        check("err_saturated", 64'(err_l), 64'd255);
        check("l_ri_after_drops", 64'(l_if.ri), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
